// File: rtl/maze_pkg.sv
// Shared encodings for the maze path replayer: move codes, verdict codes and FSM states.
package maze_pkg;

    localparam int unsigned STEP_W = 8;

    localparam logic [1:0] MV_UP    = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_DOWN  = 2'b10;
    localparam logic [1:0] MV_LEFT  = 2'b11;

    localparam logic [1:0] ERR_FAIL     = 2'b00;
    localparam logic [1:0] ERR_OOB      = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_STALL    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_REPLAY = 3'd2,
        ST_OK     = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

endpackage

// File: rtl/maze_pos_step.sv
// Combinational single-move position update; the extra MSB catches both
// underflow below 0 and overflow past 2^W-1.
module maze_pos_step
    import maze_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [1:0]   move_i,
    output logic [W-1:0] nx_o,
    output logic [W-1:0] ny_o,
    output logic         oob_o
);

    logic [W:0] nxe;
    logic [W:0] nye;

    always_comb begin
        nxe = {1'b0, x_i};
        nye = {1'b0, y_i};
        case (move_i)
            MV_UP:    nye = {1'b0, y_i} - (W+1)'(1);
            MV_RIGHT: nxe = {1'b0, x_i} + (W+1)'(1);
            MV_DOWN:  nye = {1'b0, y_i} + (W+1)'(1);
            default:  nxe = {1'b0, x_i} - (W+1)'(1);
        endcase
        oob_o = nxe[W] | nye[W];
        nx_o  = nxe[W-1:0];
        ny_o  = nye[W-1:0];
    end

endmodule

// File: rtl/maze_path_replayer.sv
// Replays the solver's move stream from (0,0), tracks position and step count,
// and reports a sticky OK / error verdict.
module maze_path_replayer
    import maze_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned GOAL_X    = 15,
    parameter int unsigned GOAL_Y    = 15,
    parameter int unsigned MAX_STEPS = 255,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              solver_done_i,
    input  logic              solver_fail_i,
    input  logic [1:0]        move_i,
    input  logic              move_valid_i,
    output logic              run_o,
    output logic [W-1:0]      x_o,
    output logic [W-1:0]      y_o,
    output logic [STEP_W-1:0] steps_o,
    output logic              busy_o,
    output logic              path_ok_o,
    output logic              path_err_o,
    output logic [1:0]        err_code_o
);

    localparam int unsigned SW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [W-1:0]      x_q, x_d, y_q, y_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              run_q, run_d, busy_q, busy_d;
    logic              ok_q, ok_d, err_q, err_d;

    logic [W-1:0] nx, ny;
    logic         oob;

    maze_pos_step #(.W(W)) u_pos_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .move_i (move_i),
        .nx_o   (nx),
        .ny_o   (ny),
        .oob_o  (oob)
    );

    // Next-state, datapath and verdict decode; flags are registered from state_d.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        steps_d    = steps_q;
        stall_d    = stall_q;
        err_code_d = err_code_q;

        if (arm_i) begin
            state_d    = ST_WAIT;
            x_d        = '0;
            y_d        = '0;
            steps_d    = '0;
            stall_d    = '0;
            err_code_d = ERR_FAIL;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (solver_fail_i) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_FAIL;
                    end else if (solver_done_i) begin
                        state_d = ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    if (move_valid_i) begin
                        if (oob) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_OOB;
                        end else if (steps_q == STEP_W'(MAX_STEPS)) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_OVERFLOW;
                        end else begin
                            x_d     = nx;
                            y_d     = ny;
                            steps_d = steps_q + STEP_W'(1);
                            stall_d = '0;
                            if (nx == W'(GOAL_X) && ny == W'(GOAL_Y)) begin
                                state_d = ST_OK;
                            end
                        end
                    end else if (stall_q == SW'(TIMEOUT)) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_STALL;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end

        run_d  = (state_d == ST_REPLAY);
        busy_d = (state_d == ST_WAIT) || (state_d == ST_REPLAY);
        ok_d   = (state_d == ST_OK);
        err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            steps_q    <= '0;
            stall_q    <= '0;
            err_code_q <= ERR_FAIL;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            steps_q    <= steps_d;
            stall_q    <= stall_d;
            err_code_q <= err_code_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign run_o      = run_q;
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign steps_o    = steps_q;
    assign busy_o     = busy_q;
    assign path_ok_o  = ok_q;
    assign path_err_o = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_maze_path_replayer.sv
// Directed bench for maze_path_replayer: default instance plus a MAX_STEPS=4 instance.
module tb_maze_path_replayer;
    import maze_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm, solver_done, solver_fail, move_valid;
    logic [1:0] move;

    logic       run_o, busy_o, ok_o, err_o;
    logic [1:0] code_o;
    logic [3:0] x_o, y_o;
    logic [7:0] steps_o;

    logic       run2, busy2, ok2, err2;
    logic [1:0] code2;
    logic [3:0] x2, y2;
    logic [7:0] steps2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    maze_path_replayer dut (
        .clk(clk), .rst(rst), .arm_i(arm), .solver_done_i(solver_done),
        .solver_fail_i(solver_fail), .move_i(move), .move_valid_i(move_valid),
        .run_o(run_o), .x_o(x_o), .y_o(y_o), .steps_o(steps_o), .busy_o(busy_o),
        .path_ok_o(ok_o), .path_err_o(err_o), .err_code_o(code_o)
    );

    maze_path_replayer #(.MAX_STEPS(4)) dut_ovf (
        .clk(clk), .rst(rst), .arm_i(arm), .solver_done_i(solver_done),
        .solver_fail_i(solver_fail), .move_i(move), .move_valid_i(move_valid),
        .run_o(run2), .x_o(x2), .y_o(y2), .steps_o(steps2), .busy_o(busy2),
        .path_ok_o(ok2), .path_err_o(err2), .err_code_o(code2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic e_run, input logic e_busy,
                              input logic e_ok, input logic e_err, input logic [1:0] e_code,
                              input logic [3:0] e_x, input logic [3:0] e_y, input logic [7:0] e_steps);
        check({tag, ".run"},   32'(run_o),   32'(e_run));
        check({tag, ".busy"},  32'(busy_o),  32'(e_busy));
        check({tag, ".ok"},    32'(ok_o),    32'(e_ok));
        check({tag, ".err"},   32'(err_o),   32'(e_err));
        check({tag, ".code"},  32'(code_o),  32'(e_code));
        check({tag, ".x"},     32'(x_o),     32'(e_x));
        check({tag, ".y"},     32'(y_o),     32'(e_y));
        check({tag, ".steps"}, 32'(steps_o), 32'(e_steps));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_replay();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm.busy", 32'(busy_o), 32'd1);
        check("arm.run",  32'(run_o),  32'd0);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        check("done.run", 32'(run_o), 32'd1);
    endtask

    task automatic send(input logic [1:0] mv);
        move       = mv;
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
    endtask

    // 15 right then 15 down, with 'gap' idle cycles before each move.
    task automatic replay_path(input int gap);
        for (int i = 0; i < 30; i++) begin
            move_valid = 1'b0;
            repeat (gap) tick();
            move       = (i < 15) ? MV_RIGHT : MV_DOWN;
            move_valid = 1'b1;
            tick();
            if (i == 0) begin
                check("path.first_x",     32'(x_o),     32'd1);
                check("path.first_steps", 32'(steps_o), 32'd1);
            end
        end
        move_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; solver_done = 1'b0; solver_fail = 1'b0;
        move_valid = 1'b0; move = MV_UP;
        tick();
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
        rst = 1'b0;
        tick();
        expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);

        start_replay();
        replay_path(0);
        expect_out("legal", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'd15, 4'd15, 8'd30);
        tick();
        check("legal.hold_ok", 32'(ok_o), 32'd1);

        start_replay();
        check("rearm.ok_cleared", 32'(ok_o), 32'd0);
        send(MV_UP);
        expect_out("oob", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 8'd0);

        arm = 1'b1;
        tick();
        arm = 1'b0;
        solver_fail = 1'b1;
        solver_done = 1'b1;
        tick();
        solver_fail = 1'b0;
        solver_done = 1'b0;
        expect_out("fail", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 8'd0);
        tick();
        check("fail.run_stays_low", 32'(run_o), 32'd0);

        start_replay();
        send(MV_RIGHT); send(MV_LEFT); send(MV_RIGHT); send(MV_LEFT);
        check("ovf.pre_steps", 32'(steps2), 32'd4);
        check("ovf.pre_err",   32'(err2),   32'd0);
        check("ovf.pre_run",   32'(run2),   32'd1);
        send(MV_RIGHT);
        check("ovf.err",   32'(err2),   32'd1);
        check("ovf.code",  32'(code2),  32'd2);
        check("ovf.steps", 32'(steps2), 32'd4);
        check("ovf.x",     32'(x2),     32'd0);
        check("ovf.run",   32'(run2),   32'd0);
        check("ovf.main_steps", 32'(steps_o), 32'd5);

        start_replay();
        send(MV_RIGHT); send(MV_RIGHT); send(MV_RIGHT);
        repeat (15) tick();
        expect_out("stall15", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd3, 4'd0, 8'd3);
        tick();
        expect_out("stall16", 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'd3, 4'd0, 8'd3);

        start_replay();
        replay_path(15);
        expect_out("gap15", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'd15, 4'd15, 8'd30);

        start_replay();
        for (int i = 0; i < 5; i++) send(MV_RIGHT);
        expect_out("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 4'd0, 8'd5);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        expect_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);

        start_replay();
        replay_path(0);
        expect_out("rearm_legal", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'd15, 4'd15, 8'd30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
